// File: rtl/aes_block_dispatcher.sv
// aes_block_dispatcher: packs stream words into 128-bit blocks, deals them
// round-robin to N_LANES AES engine lanes, gathers the results back in the
// same lane order and serialises them onto the output word stream.
// A small IDLE/RUN/DONE controller frames each job of n_blocks blocks.
module aes_block_dispatcher #(
    parameter int DATA_WIDTH = 32,
    parameter int N_LANES    = 2,
    parameter int CNT_W      = 16
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   clear_i,
    input  logic                   start_i,
    input  logic [CNT_W-1:0]       n_blocks_i,
    input  logic                   in_valid_i,
    input  logic [DATA_WIDTH-1:0]  in_data_i,
    output logic                   in_ready_o,
    output logic [N_LANES-1:0]     lane_valid_o,
    output logic [N_LANES*128-1:0] lane_data_o,
    input  logic [N_LANES-1:0]     lane_ready_i,
    input  logic [N_LANES-1:0]     res_valid_i,
    input  logic [N_LANES*128-1:0] res_data_i,
    output logic [N_LANES-1:0]     res_ready_o,
    output logic                   out_valid_o,
    output logic [DATA_WIDTH-1:0]  out_data_o,
    input  logic                   out_ready_i,
    output logic                   busy_o,
    output logic                   done_o,
    output logic [CNT_W-1:0]       blk_in_cnt_o,
    output logic [CNT_W-1:0]       blk_out_cnt_o
);

    localparam int WPB   = 128 / DATA_WIDTH;
    localparam int PTR_W = (N_LANES > 1) ? $clog2(N_LANES) : 1;
    localparam int IDX_W = (WPB > 1) ? $clog2(WPB) : 1;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WPB - 1);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(N_LANES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] n_blocks_q, n_blocks_d;
    logic [127:0]     pack_buf_q, pack_buf_d;
    logic [IDX_W-1:0] pack_idx_q, pack_idx_d;
    logic             pack_full_q, pack_full_d;
    logic [PTR_W-1:0] dptr_q, dptr_d;
    logic [127:0]     unpack_buf_q, unpack_buf_d;
    logic [IDX_W-1:0] unpack_idx_q, unpack_idx_d;
    logic             unpack_full_q, unpack_full_d;
    logic [PTR_W-1:0] cptr_q, cptr_d;
    logic [CNT_W-1:0] blk_in_cnt_q, blk_in_cnt_d;
    logic [CNT_W-1:0] blk_out_cnt_q, blk_out_cnt_d;

    logic         in_hs, lane_hs, res_hs, out_hs;
    logic [127:0] res_sel;

    // Output decode: steer the pack buffer to the dispatch lane and the
    // collect-ready to the collect lane; everything else stays quiet.
    always_comb begin
        in_ready_o   = (state_q == RUN) && !pack_full_q && (blk_in_cnt_q < n_blocks_q);
        lane_valid_o = '0;
        lane_data_o  = '0;
        res_ready_o  = '0;
        res_sel      = '0;
        for (int k = 0; k < N_LANES; k++) begin
            if (dptr_q == PTR_W'(k)) begin
                lane_valid_o[k] = pack_full_q;
                if (pack_full_q) begin
                    lane_data_o[128*k +: 128] = pack_buf_q;
                end
            end
            if (cptr_q == PTR_W'(k)) begin
                res_ready_o[k] = (state_q == RUN) && !unpack_full_q;
                res_sel        = res_data_i[128*k +: 128];
            end
        end
        out_valid_o   = unpack_full_q;
        out_data_o    = unpack_full_q ? unpack_buf_q[DATA_WIDTH*unpack_idx_q +: DATA_WIDTH] : '0;
        busy_o        = (state_q == RUN);
        done_o        = (state_q == DONE);
        blk_in_cnt_o  = blk_in_cnt_q;
        blk_out_cnt_o = blk_out_cnt_q;
        // Only one lane bit can be set in each vector, so OR-reduction
        // tells whether the selected lane handshakes.
        in_hs   = in_valid_i && in_ready_o;
        lane_hs = |(lane_valid_o & lane_ready_i);
        res_hs  = |(res_ready_o & res_valid_i);
        out_hs  = out_valid_o && out_ready_i;
    end

    // Next-state: job FSM plus the concurrent pack/dispatch/collect/unpack paths.
    always_comb begin
        state_d       = state_q;
        n_blocks_d    = n_blocks_q;
        pack_buf_d    = pack_buf_q;
        pack_idx_d    = pack_idx_q;
        pack_full_d   = pack_full_q;
        dptr_d        = dptr_q;
        unpack_buf_d  = unpack_buf_q;
        unpack_idx_d  = unpack_idx_q;
        unpack_full_d = unpack_full_q;
        cptr_d        = cptr_q;
        blk_in_cnt_d  = blk_in_cnt_q;
        blk_out_cnt_d = blk_out_cnt_q;

        unique case (state_q)
            IDLE: begin
                if (start_i) begin
                    n_blocks_d    = n_blocks_i;
                    pack_buf_d    = '0;
                    pack_idx_d    = '0;
                    pack_full_d   = 1'b0;
                    dptr_d        = '0;
                    unpack_buf_d  = '0;
                    unpack_idx_d  = '0;
                    unpack_full_d = 1'b0;
                    cptr_d        = '0;
                    blk_in_cnt_d  = '0;
                    blk_out_cnt_d = '0;
                    state_d       = (n_blocks_i == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                // Pack: word i fills bits [DATA_WIDTH*i +: DATA_WIDTH].
                if (in_hs) begin
                    pack_buf_d[DATA_WIDTH*pack_idx_q +: DATA_WIDTH] = in_data_i;
                    if (pack_idx_q == LAST_IDX) begin
                        pack_idx_d  = '0;
                        pack_full_d = 1'b1;
                    end else begin
                        pack_idx_d = pack_idx_q + IDX_W'(1);
                    end
                end
                // Dispatch: in_ready is low while full, so no refill clash.
                if (lane_hs) begin
                    pack_full_d  = 1'b0;
                    dptr_d       = (dptr_q == LAST_PTR) ? '0 : dptr_q + PTR_W'(1);
                    blk_in_cnt_d = blk_in_cnt_q + CNT_W'(1);
                end
                // Collect: only the lane at cptr is ever granted, which keeps job order.
                if (res_hs) begin
                    unpack_buf_d  = res_sel;
                    unpack_full_d = 1'b1;
                    cptr_d        = (cptr_q == LAST_PTR) ? '0 : cptr_q + PTR_W'(1);
                end
                // Unpack: the last word of the last block closes the job.
                if (out_hs) begin
                    if (unpack_idx_q == LAST_IDX) begin
                        unpack_idx_d  = '0;
                        unpack_full_d = 1'b0;
                        blk_out_cnt_d = blk_out_cnt_q + CNT_W'(1);
                        if ((blk_out_cnt_q + CNT_W'(1)) == n_blocks_q) begin
                            state_d = DONE;
                        end
                    end else begin
                        unpack_idx_d = unpack_idx_q + IDX_W'(1);
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Soft clear wins over start and every handshake, and skips DONE.
        if (clear_i) begin
            state_d       = IDLE;
            n_blocks_d    = '0;
            pack_buf_d    = '0;
            pack_idx_d    = '0;
            pack_full_d   = 1'b0;
            dptr_d        = '0;
            unpack_buf_d  = '0;
            unpack_idx_d  = '0;
            unpack_full_d = 1'b0;
            cptr_d        = '0;
            blk_in_cnt_d  = '0;
            blk_out_cnt_d = '0;
        end
    end

    // State register with asynchronous active-low reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q       <= IDLE;
            n_blocks_q    <= '0;
            pack_buf_q    <= '0;
            pack_idx_q    <= '0;
            pack_full_q   <= 1'b0;
            dptr_q        <= '0;
            unpack_buf_q  <= '0;
            unpack_idx_q  <= '0;
            unpack_full_q <= 1'b0;
            cptr_q        <= '0;
            blk_in_cnt_q  <= '0;
            blk_out_cnt_q <= '0;
        end else begin
            state_q       <= state_d;
            n_blocks_q    <= n_blocks_d;
            pack_buf_q    <= pack_buf_d;
            pack_idx_q    <= pack_idx_d;
            pack_full_q   <= pack_full_d;
            dptr_q        <= dptr_d;
            unpack_buf_q  <= unpack_buf_d;
            unpack_idx_q  <= unpack_idx_d;
            unpack_full_q <= unpack_full_d;
            cptr_q        <= cptr_d;
            blk_in_cnt_q  <= blk_in_cnt_d;
            blk_out_cnt_q <= blk_out_cnt_d;
        end
    end

endmodule

// File: tb/tb_aes_block_dispatcher.sv
// Directed bench: a 2-lane instance (A) for ordering, stall, zero-job and
// clear cases, and a 3-lane instance (B) for non-power-of-2 wrap with
// randomly throttled lanes. Lanes are echo models with a settable delay.
module tb_aes_block_dispatcher;

    int checks = 0;
    int errors = 0;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [383:0] obs, input logic [383:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // ---------------- instance A: 32-bit words, 2 lanes ----------------
    logic         a_clear = 1'b0, a_start = 1'b0, a_in_valid = 1'b0;
    logic [15:0]  a_n_blocks = '0;
    logic [31:0]  a_in_data = '0;
    logic         a_in_ready, a_out_valid, a_out_ready, a_busy, a_done;
    logic [1:0]   a_lane_valid, a_lane_ready, a_res_valid, a_res_ready;
    logic [255:0] a_lane_data;
    logic [255:0] a_res_data = '0;
    logic [31:0]  a_out_data;
    logic [15:0]  a_blk_in, a_blk_out;

    aes_block_dispatcher #(.DATA_WIDTH(32), .N_LANES(2), .CNT_W(16)) dut_a (
        .clk_i(clk), .rst_ni(rst_n), .clear_i(a_clear), .start_i(a_start),
        .n_blocks_i(a_n_blocks), .in_valid_i(a_in_valid), .in_data_i(a_in_data),
        .in_ready_o(a_in_ready), .lane_valid_o(a_lane_valid), .lane_data_o(a_lane_data),
        .lane_ready_i(a_lane_ready), .res_valid_i(a_res_valid), .res_data_i(a_res_data),
        .res_ready_o(a_res_ready), .out_valid_o(a_out_valid), .out_data_o(a_out_data),
        .out_ready_i(a_out_ready), .busy_o(a_busy), .done_o(a_done),
        .blk_in_cnt_o(a_blk_in), .blk_out_cnt_o(a_blk_out)
    );

    // ---------------- instance B: 32-bit words, 3 lanes ----------------
    logic         b_clear = 1'b0, b_start = 1'b0, b_in_valid = 1'b0;
    logic [15:0]  b_n_blocks = '0;
    logic [31:0]  b_in_data = '0;
    logic         b_in_ready, b_out_valid, b_busy, b_done;
    logic         b_out_ready = 1'b1;
    logic [2:0]   b_lane_valid, b_lane_ready, b_res_valid, b_res_ready;
    logic [383:0] b_lane_data;
    logic [383:0] b_res_data = '0;
    logic [31:0]  b_out_data;
    logic [15:0]  b_blk_in, b_blk_out;

    aes_block_dispatcher #(.DATA_WIDTH(32), .N_LANES(3), .CNT_W(16)) dut_b (
        .clk_i(clk), .rst_ni(rst_n), .clear_i(b_clear), .start_i(b_start),
        .n_blocks_i(b_n_blocks), .in_valid_i(b_in_valid), .in_data_i(b_in_data),
        .in_ready_o(b_in_ready), .lane_valid_o(b_lane_valid), .lane_data_o(b_lane_data),
        .lane_ready_i(b_lane_ready), .res_valid_i(b_res_valid), .res_data_i(b_res_data),
        .res_ready_o(b_res_ready), .out_valid_o(b_out_valid), .out_data_o(b_out_data),
        .out_ready_i(b_out_ready), .busy_o(b_busy), .done_o(b_done),
        .blk_in_cnt_o(b_blk_in), .blk_out_cnt_o(b_blk_out)
    );

    // ---------------- lane echo models ----------------
    logic [1:0] a_lbusy, a_rv;
    int         a_lcnt [2];
    int         a_delay [2] = '{3, 3};
    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (a_clear || !rst_n) begin
                a_lbusy[k] <= 1'b0; a_rv[k] <= 1'b0;
            end else if (a_rv[k]) begin
                if (a_res_ready[k]) begin a_rv[k] <= 1'b0; a_lbusy[k] <= 1'b0; end
            end else if (a_lbusy[k]) begin
                if (a_lcnt[k] <= 1) a_rv[k] <= 1'b1; else a_lcnt[k] <= a_lcnt[k] - 1;
            end else if (a_lane_valid[k] && a_lane_ready[k]) begin
                a_lbusy[k] <= 1'b1; a_lcnt[k] <= a_delay[k];
                a_res_data[128*k +: 128] <= a_lane_data[128*k +: 128];
            end
        end
    end
    assign a_lane_ready = ~a_lbusy;
    assign a_res_valid  = a_rv;

    logic [2:0] b_lbusy, b_rv;
    logic [2:0] b_rnd = 3'b111;
    int         b_lcnt [3];
    always @(posedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (b_clear || !rst_n) begin
                b_lbusy[k] <= 1'b0; b_rv[k] <= 1'b0;
            end else if (b_rv[k]) begin
                if (b_res_ready[k]) begin b_rv[k] <= 1'b0; b_lbusy[k] <= 1'b0; end
            end else if (b_lbusy[k]) begin
                if (b_lcnt[k] <= 1) b_rv[k] <= 1'b1; else b_lcnt[k] <= b_lcnt[k] - 1;
            end else if (b_lane_valid[k] && b_lane_ready[k]) begin
                b_lbusy[k] <= 1'b1; b_lcnt[k] <= 2;
                b_res_data[128*k +: 128] <= b_lane_data[128*k +: 128];
            end
        end
    end
    always @(negedge clk) b_rnd <= 3'($urandom);
    assign b_lane_ready = ~b_lbusy & b_rnd;
    assign b_res_valid  = b_rv;

    // A output-ready: constant 1, or the repeating 1,0,0,1 pattern.
    logic       a_omode = 1'b0;
    logic [3:0] a_pat   = 4'b1001;
    logic [31:0] a_cyc  = '0;
    always @(negedge clk) a_cyc <= a_cyc + 1;
    assign a_out_ready = a_omode ? a_pat[a_cyc[1:0]] : 1'b1;

    // ---------------- monitors ----------------
    logic [31:0]  a_outq [$];
    int           a_dispq [$];
    logic [127:0] a_dispdata [$];
    logic [31:0]  b_outq [$];
    int           b_dispq [$];
    int a_done_cnt = 0, a_r1wait = 0, a_stalls = 0, a_viol = 0;
    logic        a_pstall = 1'b0;
    logic [31:0] a_pdata  = '0;

    always @(posedge clk) begin
        if (rst_n && !a_clear) begin
            if (a_out_valid && a_out_ready) a_outq.push_back(a_out_data);
            for (int k = 0; k < 2; k++)
                if (a_lane_valid[k] && a_lane_ready[k]) begin
                    a_dispq.push_back(k);
                    a_dispdata.push_back(a_lane_data[128*k +: 128]);
                end
            if (a_done) a_done_cnt <= a_done_cnt + 1;
            if (a_res_valid[1] && !a_res_ready[1]) a_r1wait <= a_r1wait + 1;
            if (a_pstall && (!a_out_valid || a_out_data !== a_pdata)) a_viol <= a_viol + 1;
            if (a_out_valid && !a_out_ready) a_stalls <= a_stalls + 1;
        end
        a_pstall <= a_out_valid && !a_out_ready;
        a_pdata  <= a_out_data;
    end

    always @(posedge clk) begin
        if (rst_n) begin
            if (b_out_valid && b_out_ready) b_outq.push_back(b_out_data);
            for (int k = 0; k < 3; k++)
                if (b_lane_valid[k] && b_lane_ready[k]) b_dispq.push_back(k);
        end
    end

    // ---------------- helper tasks ----------------
    task automatic start_a(input logic [15:0] nb);
        a_n_blocks = nb; a_start = 1'b1;
        @(negedge clk);
        a_start = 1'b0;
    endtask

    task automatic feed_a(input logic [31:0] w);
        int n = 0;
        a_in_valid = 1'b1; a_in_data = w;
        while (!a_in_ready && n < 200) begin @(negedge clk); n++; end
        if (n >= 200) begin
            chk("feed_a timeout", n, 0);
        end else begin
            @(negedge clk);
        end
        a_in_valid = 1'b0;
    endtask

    task automatic feed_b(input logic [31:0] w);
        int n = 0;
        b_in_valid = 1'b1; b_in_data = w;
        while (!b_in_ready && n < 500) begin @(negedge clk); n++; end
        if (n >= 500) begin
            chk("feed_b timeout", n, 0);
        end else begin
            @(negedge clk);
        end
        b_in_valid = 1'b0;
    endtask

    task automatic wait_done_a(input int budget, input string tag);
        int n = 0;
        while (a_done !== 1'b1 && n < budget) begin @(negedge clk); n++; end
        checks++;
        if (a_done !== 1'b1) begin
            errors++;
            $error("FAIL %s: wait expired after %0d cycles", tag, n);
        end
    endtask

    task automatic wait_done_b(input int budget, input string tag);
        int n = 0;
        while (b_done !== 1'b1 && n < budget) begin @(negedge clk); n++; end
        checks++;
        if (b_done !== 1'b1) begin
            errors++;
            $error("FAIL %s: wait expired after %0d cycles", tag, n);
        end
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int base, dbase, dc;

        // Reset state
        #2 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst busy", a_busy, 1'b0);
        chk("rst done", a_done, 1'b0);
        chk("rst in_ready", a_in_ready, 1'b0);
        chk("rst lane_valid", a_lane_valid, 2'b00);
        chk("rst lane_data", a_lane_data, 256'd0);
        chk("rst res_ready", a_res_ready, 2'b00);
        chk("rst out_valid", a_out_valid, 1'b0);
        chk("rst out_data", a_out_data, 32'd0);
        chk("rst blk_in", a_blk_in, 16'd0);
        chk("rst blk_out", a_blk_out, 16'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // T1: 4 blocks, words 0..15, echo lanes with 3-cycle delay
        base = a_outq.size(); dbase = a_dispq.size(); dc = a_done_cnt;
        start_a(16'd4);
        chk("t1 busy", a_busy, 1'b1);
        for (int i = 0; i < 4; i++) feed_a(32'(i));
        chk("t1 first lane_valid", a_lane_valid, 2'b01);
        chk("t1 lane0 data", a_lane_data[127:0], 128'h00000003_00000002_00000001_00000000);
        for (int i = 4; i < 16; i++) feed_a(32'(i));
        wait_done_a(300, "t1 done timeout");
        chk("t1 busy at done", a_busy, 1'b0);
        chk("t1 blk_in", a_blk_in, 16'd4);
        chk("t1 blk_out", a_blk_out, 16'd4);
        @(negedge clk);
        chk("t1 done drop", a_done, 1'b0);
        chk("t1 done pulses", a_done_cnt - dc, 1);
        chk("t1 disp count", a_dispq.size() - dbase, 4);
        chk("t1 disp 0", a_dispq[dbase+0], 0);
        chk("t1 disp 1", a_dispq[dbase+1], 1);
        chk("t1 disp 2", a_dispq[dbase+2], 0);
        chk("t1 disp 3", a_dispq[dbase+3], 1);
        chk("t1 disp block0", a_dispdata[dbase], 128'h00000003_00000002_00000001_00000000);
        chk("t1 out count", a_outq.size() - base, 16);
        for (int i = 0; i < 16; i++) chk("t1 out word", a_outq[base+i], 32'(i));

        // T2: lane 1 answers first; must wait for lane 0
        a_delay[0] = 12; a_delay[1] = 1;
        base = a_outq.size(); dc = a_r1wait;
        start_a(16'd2);
        for (int i = 0; i < 8; i++) feed_a(32'h100 + 32'(i));
        wait_done_a(300, "t2 done timeout");
        @(negedge clk);
        chk("t2 lane1 held", (a_r1wait - dc) > 0, 1'b1);
        chk("t2 out count", a_outq.size() - base, 8);
        for (int i = 0; i < 8; i++) chk("t2 out word", a_outq[base+i], 32'h100 + 32'(i));

        // T3: output stalls with ready pattern 1,0,0,1
        a_delay[0] = 3; a_delay[1] = 3;
        a_omode = 1'b1;
        base = a_outq.size(); dc = a_stalls;
        start_a(16'd2);
        for (int i = 0; i < 8; i++) feed_a(32'h200 + 32'(i));
        wait_done_a(400, "t3 done timeout");
        @(negedge clk);
        a_omode = 1'b0;
        chk("t3 stalls seen", (a_stalls - dc) > 0, 1'b1);
        chk("t3 stall stability", a_viol, 0);
        chk("t3 out count", a_outq.size() - base, 8);
        for (int i = 0; i < 8; i++) chk("t3 out word", a_outq[base+i], 32'h200 + 32'(i));

        // T4: zero-block job goes straight to DONE
        dbase = a_dispq.size();
        start_a(16'd0);
        chk("t4 done", a_done, 1'b1);
        chk("t4 busy", a_busy, 1'b0);
        chk("t4 lane_valid", a_lane_valid, 2'b00);
        @(negedge clk);
        chk("t4 done drop", a_done, 1'b0);
        chk("t4 busy after", a_busy, 1'b0);
        chk("t4 no dispatch", a_dispq.size() - dbase, 0);
        chk("t4 blk_out", a_blk_out, 16'd0);

        // T5: clear mid-job after 2 of 4 blocks, then a 1-block job
        start_a(16'd4);
        for (int i = 0; i < 8; i++) feed_a(32'h500 + 32'(i));
        dc = 0;
        while (a_blk_in != 16'd2 && dc < 100) begin @(negedge clk); dc++; end
        chk("t5 reach 2 blocks", a_blk_in, 16'd2);
        dc = a_done_cnt;
        a_clear = 1'b1;
        @(negedge clk);
        a_clear = 1'b0;
        chk("t5 busy", a_busy, 1'b0);
        chk("t5 done", a_done, 1'b0);
        chk("t5 in_ready", a_in_ready, 1'b0);
        chk("t5 lane_valid", a_lane_valid, 2'b00);
        chk("t5 lane_data", a_lane_data, 256'd0);
        chk("t5 res_ready", a_res_ready, 2'b00);
        chk("t5 out_valid", a_out_valid, 1'b0);
        chk("t5 out_data", a_out_data, 32'd0);
        chk("t5 blk_in", a_blk_in, 16'd0);
        chk("t5 blk_out", a_blk_out, 16'd0);
        repeat (2) @(negedge clk);
        chk("t5 no done", a_done_cnt - dc, 0);
        base = a_outq.size(); dbase = a_dispq.size();
        start_a(16'd1);
        for (int i = 0; i < 4; i++) feed_a(32'h300 + 32'(i));
        wait_done_a(200, "t5 done timeout");
        chk("t5 blk_out after", a_blk_out, 16'd1);
        @(negedge clk);
        chk("t5 disp count", a_dispq.size() - dbase, 1);
        chk("t5 disp lane", a_dispq[dbase], 0);
        chk("t5 out count", a_outq.size() - base, 4);
        for (int i = 0; i < 4; i++) chk("t5 out word", a_outq[base+i], 32'h300 + 32'(i));

        // T6: 3 lanes, 7 blocks, random lane readiness, stray start ignored
        b_n_blocks = 16'd7; b_start = 1'b1;
        @(negedge clk);
        b_start = 1'b0;
        chk("t6 busy", b_busy, 1'b1);
        for (int i = 0; i < 10; i++) feed_b(32'h400 + 32'(i));
        b_n_blocks = 16'd2; b_start = 1'b1;
        @(negedge clk);
        b_start = 1'b0;
        chk("t6 busy after 2nd start", b_busy, 1'b1);
        for (int i = 10; i < 28; i++) feed_b(32'h400 + 32'(i));
        wait_done_b(2000, "t6 done timeout");
        chk("t6 blk_in", b_blk_in, 16'd7);
        chk("t6 blk_out", b_blk_out, 16'd7);
        @(negedge clk);
        chk("t6 disp count", b_dispq.size(), 7);
        for (int i = 0; i < 7; i++) chk("t6 disp lane", b_dispq[i], i % 3);
        chk("t6 out count", b_outq.size(), 28);
        for (int i = 0; i < 28; i++) chk("t6 out word", b_outq[i], 32'h400 + 32'(i));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
